// File: rtl/sqrt2_mult_arbiter_pkg.sv
// Shared constants for the FFT twiddle datapath: the sqrt(2)/2 scaling factor
// and the round-robin pointer advance used by lane arbiters.
package fft_ctrl_pkg;

  localparam int SQRT2_K     = 5793;
  localparam int SQRT2_SHIFT = 13;
  localparam int DW_SAMPLE   = 16;

  // Next round-robin start position after index ptr was served.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
    return (ptr + 32'd1 >= nreq) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sqrt2_mult_arbiter_if.sv
// Requester-side bus of the shared sqrt(2)/2 multiplier: operand handshake in,
// one-hot tagged result out, plus an idle indication.
interface sqrt2_mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  // Handshake: an operand from requester i transfers in a cycle where both
  // req_valid[i] and req_ready[i] are high; while req_valid[i] is high and
  // req_ready[i] is low, req_data for lane i must stay stable. Results carry
  // no backpressure: rsp_data belongs to the lane whose rsp_valid bit is high,
  // for that single cycle only.
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               idle;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data, idle
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_data, idle
  );
endinterface

// File: rtl/sqrt2_mult_arbiter_core.sv
// Combinational ones'-complement scaler: y = x * 5793/8192, applied to the
// magnitude so positive and negative inputs truncate symmetrically.
module sqrt2_mult_core
  import fft_ctrl_pkg::*;
(
  input  logic [DW_SAMPLE-1:0] x,
  output logic [DW_SAMPLE-1:0] y
);

  localparam int PROD_W = DW_SAMPLE + SQRT2_SHIFT;

  logic [DW_SAMPLE-1:0] mag;
  logic [PROD_W-1:0]    prod;
  logic [DW_SAMPLE-1:0] scaled;

  assign mag    = x[DW_SAMPLE-1] ? ~x : x;
  assign prod   = PROD_W'(mag) * PROD_W'(SQRT2_K);
  assign scaled = prod[SQRT2_SHIFT +: DW_SAMPLE];
  assign y      = x[DW_SAMPLE-1] ? ~scaled : scaled;

endmodule

// File: rtl/sqrt2_mult_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline around one shared sqrt(2)/2
// multiplier; results return two cycles after the grant with a one-hot owner tag.
module sqrt2_mult_arbiter
  import fft_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_SAMPLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  sqrt2_mult_arbiter_if.slave bus
);

  localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic            found;
  logic [NREQ-1:0] grant;
  logic            fire;
  logic [DW-1:0]   sel_data;

  logic            s1_valid;
  logic [DW-1:0]   s1_data;
  logic [NREQ-1:0] s1_tag;
  logic [DW-1:0]   core_out;
  logic [NREQ-1:0] s2_tag;
  logic [DW-1:0]   s2_data;
  logic            s2_valid;

  // Walk the lanes starting at ptr and take the first one asking.
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr;
    cand      = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
      cand = (cand == LAST) ? '0 : cand + 1'b1;
    end
  end

  // flush and reset both suppress the grant so nothing enters a pipeline
  // that is being cleared.
  always_comb begin
    grant = '0;
    if (found && rst_n && !flush) grant[grant_idx] = 1'b1;
  end

  assign fire = |(bus.req_valid & grant);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_data = bus.req_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= PW'(rr_next(32'(grant_idx), 32'(NREQ)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= fire && !flush;
      if (fire) begin
        s1_data <= sel_data;
        s1_tag  <= grant;
      end
    end
  end

  sqrt2_mult_core u_core (
    .x (s1_data),
    .y (core_out)
  );

  // The stage-2 tag register doubles as the per-lane response valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_tag  <= '0;
      s2_data <= '0;
    end else begin
      s2_tag <= (s1_valid && !flush) ? s1_tag : '0;
      if (s1_valid) s2_data <= core_out;
    end
  end

  assign s2_valid      = |s2_tag;
  assign bus.req_ready = grant;
  assign bus.rsp_valid = s2_tag;
  assign bus.rsp_data  = s2_data;
  assign bus.idle      = ~|bus.req_valid & ~s1_valid & ~s2_valid;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
  a_rsp_onehot   : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.rsp_valid));
  a_tag_onehot   : assert property (@(posedge clk) disable iff (!rst_n) s1_valid |-> $onehot(s1_tag));

endmodule

// File: doc/sqrt2_mult_arbiter.md
# sqrt2_mult_arbiter

Round-robin arbiter and two-stage pipeline that shares one √2/2 constant multiplier among NREQ requesters (butterfly lanes of the 64-point FFT processor). Each requester hands over a 16-bit ones'-complement-signed sample with a valid/ready handshake. The product returns two cycles later, tagged to the originating requester by a one-hot response valid. The block replaces per-lane multiplier copies in the W8^1/W8^3 twiddle stages.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 16, sample width (fixed at 16 for this release)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline clear
- req_valid  in  NREQ  per-requester operand valid
- req_data  in  NREQ*DW  operands; requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  one-hot result valid, owner of rsp_data
- rsp_data  out  DW  scaled result
- idle  out  1  no request pending and pipeline empty

## Operation
- Arithmetic:
  - m = x[15] ? ~x : x
  - p = m*5793, 29-bit unsigned
  - y = p[28:13]
  - out = x[15] ? ~y : y (5793/8192 ≈ 0.70715)
- Arbitration:
  - Round-robin pointer ptr; search order ptr, ptr+1, …, wraps mod NREQ.
  - First requester with req_valid set gets req_ready (combinational from req_valid and ptr).
  - On handshake, ptr ← granted index + 1 mod NREQ.
  - With no request, ptr holds.
- At most one req_ready bit high per cycle. A requester must hold req_data stable while req_valid is high and not granted.
- Stage 1 registers the operand, a valid bit and a one-hot tag. Stage 2 registers the product and copies valid/tag to rsp_valid.
- No response backpressure: a requester must sample rsp_data in the cycle its rsp_valid bit is high.
- flush:
  - Clears the stage-1 and stage-2 valid bits. Data registers are don't-care.
  - Forces req_ready to all-zero that cycle.
  - ptr is unchanged.
- idle = ~|req_valid & ~s1_valid & ~s2_valid.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, idle=1 (with no req_valid), ptr=0, pipeline valids=0.
- Latency: handshake at edge N → rsp_valid high for exactly one cycle after edge N+2.
- Throughput: one operand per cycle, sustained across any mix of requesters.
- Simultaneous events:
  - All NREQ valid continuously → grants rotate 0,1,2,3,0,… with no gaps.
  - flush and req_valid in the same cycle → no grant; flush wins.
  - flush with data in flight → no rsp_valid for those operands.
- Reset mid-operation: in-flight results are dropped. The first grant after rst_n rises goes to the lowest-index valid requester.
- Back-to-back ops from the same requester (the only one valid) are allowed every cycle.

## Structure
- Package fft_ctrl_pkg holds:
  - SQRT2_K = 5793
  - SQRT2_SHIFT = 13
  - DW_SAMPLE = 16
  - function rr_next(ptr, NREQ)
- Sub-module sqrt2_mult_core: combinational 16b→16b scaler implementing the arithmetic rule above. It sits between stage 1 and stage 2.
- The arbiter, pointer, pipeline registers and tag logic live in this block.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 ops in flight → all outputs 0 immediately. After release, no rsp_valid appears for the dropped ops.
- Single op: requester 2 sends 0x4000 → req_ready=0b0100 same cycle; rsp_valid=0b0100 and rsp_data=0x2D42 two cycles later.
- Sign and boundaries, each issued from requester 0:
  - 0x8000 → 0xA57C
  - 0x7FFF → 0x5A83
  - 0xFFFF → 0xFFFF
  - 0x0000 → 0x0000
- Fairness: all 4 requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; each result is tagged to the correct requester.
- Flush: flush pulses one cycle after a grant and coincides with a new req_valid → the in-flight op produces no rsp_valid; no grant that cycle; the next grant follows the unchanged ptr.
- Random: 10k cycles of random req_valid/flush and random data → the scoreboard matches the arithmetic model. One-hot invariants hold on req_ready and rsp_valid. idle is consistent with pipeline state.
